// File: rtl/data_sram_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_sram_if : core data-SRAM request/response bundle (rev 1.0)
// ---------------------------------------------------------------------------
interface data_sram_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output en, output wen, output addr, output wdata, input rdata);
  modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/data_sram_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_sram_responder : byte-writable word RAM plus config register window
// rev 1.0
// ---------------------------------------------------------------------------
module data_sram_responder #(
  parameter int          RAM_AW    = 12,
  parameter logic [15:0] CONF_HI   = 16'hbfaf,
  parameter logic [31:0] SIMU_FLAG = 32'hffff_ffff
) (
  input  wire logic        clk,
  input  wire logic        reset,
  data_sram_if.slave       bus,
  input  wire logic [7:0]  switch_in,
  output logic      [15:0] led_out,
  output logic      [31:0] num_out
);

  localparam int          c_DEPTH    = 2 ** RAM_AW;
  localparam logic [15:0] c_OFF_LED  = 16'hf000;
  localparam logic [15:0] c_OFF_NUM  = 16'hf010;
  localparam logic [15:0] c_OFF_SW   = 16'hf020;
  localparam logic [15:0] c_OFF_TMR  = 16'he000;
  localparam logic [15:0] c_OFF_SIMU = 16'hf030;

  logic [31:0] mem [0:c_DEPTH-1];

  logic [15:0]       r_led;
  logic [31:0]       r_num;
  logic [31:0]       r_timer;
  logic [31:0]       r_rdata;

  logic              w_conf_hit;
  logic              w_conf_sel;
  logic              w_ram_sel;
  logic              w_full;
  logic [15:0]       w_off;
  logic [RAM_AW-1:0] w_idx;
  logic [31:0]       w_conf_rdata;
  logic              w_wr_led;
  logic              w_wr_num;
  logic              w_wr_tmr;

  assign w_conf_hit = (bus.addr[31:16] == CONF_HI);
  assign w_conf_sel = bus.en && w_conf_hit;
  assign w_ram_sel  = bus.en && !w_conf_hit;
  assign w_full     = (bus.wen == 4'hf);
  assign w_off      = bus.addr[15:0];
  assign w_idx      = bus.addr[RAM_AW+1:2];

  // Partial-byte writes never touch config registers.
  assign w_wr_led = w_conf_sel && w_full && (w_off == c_OFF_LED);
  assign w_wr_num = w_conf_sel && w_full && (w_off == c_OFF_NUM);
  assign w_wr_tmr = w_conf_sel && w_full && (w_off == c_OFF_TMR);

  always_comb begin
    w_conf_rdata = 32'h0;
    case (w_off)
      c_OFF_LED:  w_conf_rdata = {16'h0, r_led};
      c_OFF_NUM:  w_conf_rdata = r_num;
      c_OFF_SW:   w_conf_rdata = {24'h0, switch_in};
      c_OFF_TMR:  w_conf_rdata = r_timer;
      c_OFF_SIMU: w_conf_rdata = SIMU_FLAG;
      default:    w_conf_rdata = 32'h0;
    endcase
  end

  // RAM contents survive reset; a request in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (w_ram_sel && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wen[i]) begin
          mem[w_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= 32'h0;
    end else if (w_ram_sel) begin
      r_rdata <= mem[w_idx];
    end else if (w_conf_sel) begin
      r_rdata <= w_conf_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led   <= 16'h0;
      r_num   <= 32'h0;
      r_timer <= 32'h0;
    end else begin
      if (w_wr_led) r_led <= bus.wdata[15:0];
      if (w_wr_num) r_num <= bus.wdata;
      r_timer <= (w_wr_tmr ? bus.wdata : r_timer) + 32'd1;
    end
  end

  assign bus.rdata = r_rdata;
  assign led_out   = r_led;
  assign num_out   = r_num;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_data_sram_responder : scoreboard bench with a transaction-level model
// rev 1.0
// ---------------------------------------------------------------------------
module tb_data_sram_responder;

  logic        clk;
  logic        reset;
  logic [7:0]  switch_in;
  logic [15:0] led_out;
  logic [31:0] num_out;

  data_sram_if bus ();

  data_sram_responder dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .switch_in (switch_in),
    .led_out   (led_out),
    .num_out   (num_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] rd;
    logic [31:0] mask;
    logic [15:0] led;
    logic [31:0] num;
  } exp_t;

  exp_t sbq[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state: memory as known bytes only, plus config registers.
  logic [7:0]  m_mem_b [int];
  logic [31:0] m_timer = 32'h0;
  logic [15:0] m_led   = 16'h0;
  logic [31:0] m_num   = 32'h0;
  logic [31:0] m_rd    = 32'h0;
  logic [31:0] m_mask  = 32'h0;

  always @(posedge clk) cyc++;

  task automatic drive(input logic rst, input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
    logic [7:0]  sw;
    logic [31:0] nt;
    int          w;
    int          key;
    exp_t        e;
    @(posedge clk);
    #1;
    sw        = 8'($urandom);
    reset     = rst;
    bus.en    = en;
    bus.wen   = wen;
    bus.addr  = addr;
    bus.wdata = wdata;
    switch_in = sw;
    nt = m_timer + 32'd1;
    if (rst) begin
      m_rd = 32'h0; m_mask = 32'hffff_ffff; m_led = 16'h0; m_num = 32'h0; nt = 32'h0;
    end else if (en) begin
      if (addr[31:16] == 16'hbfaf) begin
        m_mask = 32'hffff_ffff;
        case (addr[15:0])
          16'hf000: m_rd = {16'h0, m_led};
          16'hf010: m_rd = m_num;
          16'hf020: m_rd = {24'h0, sw};
          16'he000: m_rd = m_timer;
          16'hf030: m_rd = 32'hffff_ffff;
          default:  m_rd = 32'h0;
        endcase
        if (wen == 4'hf) begin
          case (addr[15:0])
            16'hf000: m_led = wdata[15:0];
            16'hf010: m_num = wdata;
            16'he000: nt = wdata + 32'd1;
            default: ;
          endcase
        end
      end else begin
        w = int'(addr[13:2]);
        for (int b = 0; b < 4; b++) begin
          key = w * 4 + b;
          if (m_mem_b.exists(key)) begin
            m_rd[8*b +: 8]   = m_mem_b[key];
            m_mask[8*b +: 8] = 8'hff;
          end else begin
            m_rd[8*b +: 8]   = 8'h00;
            m_mask[8*b +: 8] = 8'h00;
          end
        end
        for (int b = 0; b < 4; b++) begin
          if (wen[b]) m_mem_b[w * 4 + b] = wdata[8*b +: 8];
        end
      end
    end
    m_timer = nt;
    e.due = cyc + 1; e.rd = m_rd; e.mask = m_mask; e.led = m_led; e.num = m_num;
    sbq.push_back(e);
  endtask

  // Monitor: one expected response per clock, compared after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        n_tests++;
        if ((bus.rdata & e.mask) !== (e.rd & e.mask)) begin
          n_fail++;
          $display("FAIL rdata cyc=%0d got=%h exp=%h mask=%h", cyc, bus.rdata, e.rd, e.mask);
        end
        n_tests++;
        if (led_out !== e.led) begin
          n_fail++;
          $display("FAIL led_out cyc=%0d got=%h exp=%h", cyc, led_out, e.led);
        end
        n_tests++;
        if (num_out !== e.num) begin
          n_fail++;
          $display("FAIL num_out cyc=%0d got=%h exp=%h", cyc, num_out, e.num);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  localparam logic [15:0] OFFS [0:6] = '{16'hf000, 16'hf010, 16'hf020, 16'he000,
                                         16'hf030, 16'hf040, 16'h0000};

  initial begin
    logic [31:0] a;
    logic [3:0]  wn;
    logic        rs;
    logic        en;
    int          waits;
    reset = 1'b1; bus.en = 1'b0; bus.wen = 4'h0; bus.addr = 32'h0; bus.wdata = 32'h0;
    switch_in = 8'h0;

    repeat (3) drive(1, 0, 4'h0, 32'h0, 32'h0);

    // RAM byte-lane and read-first behaviour
    drive(0, 1, 4'hf, 32'h0000_0040, 32'h1234_5678);
    drive(0, 1, 4'h0, 32'h0000_0040, 32'h0);
    drive(0, 1, 4'b0010, 32'h0000_0040, 32'h0000_ab00);
    drive(0, 1, 4'h0, 32'h0000_0040, 32'h0);
    drive(0, 1, 4'hf, 32'h0000_0044, 32'h0000_0001);
    drive(0, 1, 4'h0, 32'h0000_0040, 32'h0);
    drive(0, 1, 4'h0, 32'h0000_0044, 32'h0);
    repeat (3) drive(0, 0, 4'h0, 32'h0, 32'h0);

    // Config window
    drive(0, 1, 4'hf, 32'hbfaf_f000, 32'h0000_00a5);
    drive(0, 1, 4'h3, 32'hbfaf_f000, 32'h0000_ffff);
    drive(0, 1, 4'h0, 32'hbfaf_f030, 32'h0);
    drive(0, 1, 4'h0, 32'hbfaf_f040, 32'h0);
    drive(0, 1, 4'h0, 32'hbfaf_f000, 32'h0);
    drive(0, 1, 4'h0, 32'hbfaf_f020, 32'h0);

    // Timer wrap
    drive(0, 1, 4'hf, 32'hbfaf_e000, 32'hffff_fffe);
    drive(0, 0, 4'h0, 32'h0, 32'h0);
    drive(0, 1, 4'h0, 32'hbfaf_e000, 32'h0);
    drive(0, 0, 4'h0, 32'h0, 32'h0);

    // Reset wins over a concurrent request; RAM survives
    drive(0, 1, 4'hf, 32'hbfaf_f000, 32'h0000_00ff);
    drive(0, 1, 4'hf, 32'hbfaf_f010, 32'h0000_0005);
    drive(1, 1, 4'h0, 32'h0000_0040, 32'h0);
    drive(0, 1, 4'h0, 32'h0000_0040, 32'h0);
    drive(0, 1, 4'h0, 32'hbfaf_e000, 32'h0);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) < 5) begin
        a = ($urandom & 32'h7fff_c000) | (32'($urandom_range(0, 15)) << 2)
            | 32'($urandom_range(0, 3));
      end else begin
        a = {16'hbfaf, OFFS[$urandom_range(0, 6)]};
      end
      case ($urandom_range(0, 3))
        0:       wn = 4'h0;
        1:       wn = 4'hf;
        default: wn = 4'($urandom);
      endcase
      rs = ($urandom_range(0, 59) == 0);
      en = ($urandom_range(0, 4) != 0);
      drive(rs, en, wn, a, $urandom);
    end
    drive(0, 0, 4'h0, 32'h0, 32'h0);

    waits = 0;
    while (sbq.size() > 0 && waits < 20) begin
      @(posedge clk);
      waits++;
    end
    @(negedge clk);
    #1;
    if (sbq.size() > 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d exp=0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
